// File: rtl/send_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : send_cmd_arbiter_if
// Description : Command issue / completion bus between arbiter and sender.
// Revision    : 1.0
// ============================================================================
interface send_cmd_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int CH_W   = 1
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [CH_W-1:0]   out_channel;
    logic              done;

    modport master (
        output out_valid,
        output out_addr,
        output out_channel,
        input  out_ready,
        input  done
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_channel,
        output out_ready,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/send_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : send_cmd_arbiter
// Description : Per-channel command FIFOs, round-robin issue, done tracking.
// Revision    : 1.0
// ============================================================================
module send_cmd_arbiter #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 25,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 4096,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clock_clk,
    input  logic                       reset_reset,
    input  logic [CHANNELS-1:0]        cmd_send,
    input  logic [CHANNELS*ADDR_W-1:0] start_ram_addr,
    input  logic                       ram_ready,
    send_cmd_arbiter_if.master         snd,
    output logic                       busy,
    output logic [CHANNELS-1:0]        cmd_overflow,
    output logic                       timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CHANNELS-1:0] r_cmd_prev;
    logic [CHANNELS-1:0] w_push;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_pop;
    logic [ADDR_W-1:0]   w_head [CHANNELS];
    logic [CH_W-1:0]     r_last;
    logic [CH_W-1:0]     w_grant;
    logic [CH_W-1:0]     r_chan;
    logic [ADDR_W-1:0]   r_addr;
    logic                w_found;
    logic                w_grant_en;
    logic                w_expire;

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) r_cmd_prev <= '0;
        else             r_cmd_prev <= cmd_send;
    end

    assign w_push = cmd_send & ~r_cmd_prev;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [ADDR_W-1:0] r_mem [DEPTH];
            logic [PW-1:0]     r_wptr;
            logic [PW-1:0]     r_rptr;
            logic              r_ovf;
            logic              w_wr;

            assign w_empty[i]      = (r_wptr == r_rptr);
            assign w_full[i]       = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
            assign w_pop[i]        = w_grant_en && (w_grant == CH_W'(i));
            // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
            assign w_wr            = w_push[i] && (!w_full[i] || w_pop[i]);
            assign w_head[i]       = r_mem[r_rptr[AW-1:0]];
            assign cmd_overflow[i] = r_ovf;

            always_ff @(posedge clock_clk) begin
                if (w_wr) r_mem[r_wptr[AW-1:0]] <= start_ram_addr[i*ADDR_W +: ADDR_W];
            end

            always_ff @(posedge clock_clk or posedge reset_reset) begin
                if (reset_reset) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_ovf  <= 1'b0;
                end else begin
                    if (w_wr)                r_wptr <= r_wptr + PW'(1);
                    if (w_pop[i])            r_rptr <= r_rptr + PW'(1);
                    if (w_push[i] && !w_wr)  r_ovf  <= 1'b1;
                end
            end
        end
    endgenerate

    // Round-robin: first non-empty channel after the last grant, ascending with wrap.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!w_found && !w_empty[(int'(r_last) + k) % CHANNELS]) begin
                w_found = 1'b1;
                w_grant = CH_W'((int'(r_last) + k) % CHANNELS);
            end
        end
    end

    assign w_grant_en = (r_state == S_IDLE) && ram_ready && w_found;

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_addr <= '0;
            r_chan <= '0;
            r_last <= CH_W'(CHANNELS - 1);
        end else if (w_grant_en) begin
            r_addr <= w_head[w_grant];
            r_chan <= w_grant;
            r_last <= w_grant;
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_wait_cnt;
            logic          r_tmo;

            // Pulse is precomputed so it is visible in the cycle the count reaches TIMEOUT-1.
            always_ff @(posedge clock_clk or posedge reset_reset) begin
                if (reset_reset) begin
                    r_wait_cnt <= '0;
                    r_tmo      <= 1'b0;
                end else begin
                    if (r_state == S_ISSUE)     r_wait_cnt <= '0;
                    else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + CW'(1);
                    r_tmo <= ((r_state == S_ISSUE) && snd.out_ready && (TIMEOUT == 1)) ||
                             ((r_state == S_WAIT) && !snd.done &&
                              (int'(r_wait_cnt) == TIMEOUT - 2));
                end
            end

            assign w_expire = r_tmo;
            assign timeout  = r_tmo;
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
            assign timeout  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_en)             w_state_nxt = S_ISSUE;
            S_ISSUE: if (snd.out_ready)          w_state_nxt = S_WAIT;
            S_WAIT:  if (snd.done || w_expire)   w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        snd.out_valid   = (r_state == S_ISSUE);
        snd.out_addr    = r_addr;
        snd.out_channel = r_chan;
        busy            = (r_state == S_ISSUE) || (r_state == S_WAIT);
    end
endmodule
`default_nettype wire

// File: tb/tb_send_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_send_cmd_arbiter
// Description : Directed timing scenarios plus randomized queue-model run.
// Revision    : 1.0
// ============================================================================
module tb_send_cmd_arbiter;
    localparam int CHANNELS = 2;
    localparam int ADDR_W   = 25;
    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 16;
    localparam int CH_W     = 1;

    logic                       clock_clk = 1'b0;
    logic                       reset_reset = 1'b1;
    logic [CHANNELS-1:0]        cmd_send = '0;
    logic [CHANNELS*ADDR_W-1:0] start_ram_addr = '0;
    logic                       ram_ready = 1'b0;
    logic                       busy;
    logic [CHANNELS-1:0]        cmd_overflow;
    logic                       timeout;

    send_cmd_arbiter_if #(.ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

    send_cmd_arbiter #(
        .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_clk      (clock_clk),
        .reset_reset    (reset_reset),
        .cmd_send       (cmd_send),
        .start_ram_addr (start_ram_addr),
        .ram_ready      (ram_ready),
        .snd            (bus),
        .busy           (busy),
        .cmd_overflow   (cmd_overflow),
        .timeout        (timeout)
    );

    always #5 clock_clk = ~clock_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_addr(input int ch, input logic [ADDR_W-1:0] a);
        start_ram_addr[ch*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic pulse(input logic [CHANNELS-1:0] m);
        cmd_send = m;
        @(negedge clock_clk);
        cmd_send = '0;
        @(negedge clock_clk);
    endtask

    task automatic do_reset();
        reset_reset    = 1'b1;
        cmd_send       = '0;
        ram_ready      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.done       = 1'b0;
        start_ram_addr = '0;
        repeat (2) @(negedge clock_clk);
        reset_reset = 1'b0;
    endtask

    // Wait for an issue, check it, hold off out_ready for 'hold' cycles, accept,
    // then pulse done 'done_dly' cycles into the wait (0 = never).
    task automatic serve(input int ch, input logic [ADDR_W-1:0] addr, input int hold, input int done_dly);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clock_clk);
            n++;
        end
        if (!bus.out_valid) begin
            check("issue_wait", 0, 1);
            return;
        end
        check("issue_ch", bus.out_channel, ch);
        check("issue_addr", bus.out_addr, addr);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            @(negedge clock_clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_addr", bus.out_addr, addr);
        end
        bus.out_ready = 1'b1;
        @(negedge clock_clk);
        bus.out_ready = 1'b0;
        check("drop_valid", bus.out_valid, 0);
        check("busy_wait", busy, 1);
        if (done_dly > 0) begin
            repeat (done_dly - 1) @(negedge clock_clk);
            bus.done = 1'b1;
            @(negedge clock_clk);
            bus.done = 1'b0;
            check("busy_after_done", busy, 0);
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock_clk);
            if (bus.out_valid) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    // Reference model: one queue per channel, round-robin pick at each new issue.
    task automatic run_random(input int cycles);
        logic [31:0]       mq [CHANNELS][$];
        logic [CHANNELS-1:0] m_ovf = '0;
        logic [CHANNELS-1:0] pend = '0;
        logic [ADDR_W-1:0] pend_addr [CHANNELS];
        int                m_last = CHANNELS - 1;
        int                wait_left = 0;
        int                exp_ch = 0;
        logic [31:0]       exp_addr = '0;
        bit                pv = 0, tmo_seen = 0, drained = 0, draining, found, nv, empty_all;
        logic [ADDR_W-1:0] a;
        for (int t = 0; t < cycles + 600 && !drained; t++) begin
            draining = (t >= cycles);
            @(negedge clock_clk);
            if (bus.out_valid && !pv) begin
                found = 0;
                for (int k = 1; k <= CHANNELS; k++) begin
                    if (!found && mq[(m_last + k) % CHANNELS].size() > 0) begin
                        found    = 1;
                        exp_ch   = (m_last + k) % CHANNELS;
                        exp_addr = mq[exp_ch].pop_front();
                    end
                end
                if (found) m_last = exp_ch;
                check("rnd_grant_pending", found, 1);
            end
            if (bus.out_valid) begin
                check("rnd_ch", bus.out_channel, exp_ch);
                check("rnd_addr", bus.out_addr, exp_addr);
            end
            pv = bus.out_valid;
            if (timeout) tmo_seen = 1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (pend[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(32'(pend_addr[c]));
                    else                      m_ovf[c] = 1'b1;
                end
            end
            bus.done = 1'b0;
            if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) bus.done = 1'b1;
            end
            bus.out_ready = draining ? 1'b1 : ($urandom % 3 != 0);
            if (bus.out_valid && bus.out_ready) wait_left = $urandom_range(1, 6);
            if (draining)                 ram_ready = 1'b1;
            else if ($urandom % 16 == 0)  ram_ready = ~ram_ready;
            for (int c = 0; c < CHANNELS; c++) begin
                nv = draining ? 1'b0 : ($urandom % 3 == 0);
                a  = ADDR_W'($urandom);
                set_addr(c, a);
                pend_addr[c] = a;
                pend[c]      = nv & ~cmd_send[c];
                cmd_send[c]  = nv;
            end
            empty_all = 1;
            for (int c = 0; c < CHANNELS; c++) if (mq[c].size() != 0) empty_all = 0;
            if (draining && pend == '0 && empty_all && wait_left == 0 && !bus.out_valid && !busy)
                drained = 1;
        end
        check("rnd_drained", drained, 1);
        check("rnd_overflow", cmd_overflow, m_ovf);
        check("rnd_no_timeout", tmo_seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] fa [6];
        logic [ADDR_W-1:0] oa [5];
        logic [ADDR_W-1:0] t0, t1, r0, r1, r2, r3, x;

        // Reset values
        do_reset();
        check("rst_valid", bus.out_valid, 0);
        check("rst_addr", bus.out_addr, 0);
        check("rst_chan", bus.out_channel, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", cmd_overflow, 0);
        check("rst_tmo", timeout, 0);

        // Single command: out_valid two cycles after the sampling edge
        ram_ready     = 1'b1;
        bus.out_ready = 1'b1;
        set_addr(0, 25'h000100);
        cmd_send = 2'b01;
        @(negedge clock_clk);
        check("lat_grant_cycle", bus.out_valid, 0);
        @(negedge clock_clk);
        check("lat_valid", bus.out_valid, 1);
        cmd_send = '0;
        serve(0, 25'h000100, 0, 10);

        // Fairness: three commands per channel queued while ram_ready is low
        do_reset();
        for (int p = 0; p < 3; p++) begin
            fa[2*p]   = ADDR_W'($urandom);
            fa[2*p+1] = ADDR_W'($urandom);
            set_addr(0, fa[2*p]);
            set_addr(1, fa[2*p+1]);
            pulse(2'b11);
        end
        ram_ready = 1'b1;
        for (int i = 0; i < 6; i++) serve(i % 2, fa[i], 0, 1);

        // Overflow: five pushes into a four-deep FIFO
        do_reset();
        for (int p = 0; p < 5; p++) begin
            oa[p] = ADDR_W'($urandom);
            set_addr(1, oa[p]);
            pulse(2'b10);
        end
        check("ovf_flag", cmd_overflow, 2'b10);
        ram_ready = 1'b1;
        for (int i = 0; i < 4; i++) serve(1, oa[i], 0, 1);
        expect_quiet("ovf_no_fifth", 12);
        check("ovf_sticky", cmd_overflow, 2'b10);

        // Backpressure with cmd_send held high
        do_reset();
        ram_ready = 1'b1;
        x = ADDR_W'($urandom);
        set_addr(1, x);
        cmd_send = 2'b10;
        serve(1, x, 7, 2);
        expect_quiet("held_level_once", 12);
        cmd_send = '0;

        // Timeout, stray done in IDLE and in the handshake cycle
        do_reset();
        t0 = ADDR_W'($urandom);
        t1 = ADDR_W'($urandom);
        set_addr(0, t0);
        set_addr(1, t1);
        pulse(2'b11);
        ram_ready = 1'b1;
        serve(0, t0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock_clk);
            if (k == 14) check("tmo_early", timeout, 0);
            if (k == 15) check("tmo_pulse", timeout, 1);
            if (k == 16) begin
                check("tmo_single_pulse", timeout, 0);
                check("tmo_idle", busy, 0);
                bus.done = 1'b1;
            end
        end
        @(negedge clock_clk);
        bus.done = 1'b0;
        check("tmo_next_valid", bus.out_valid, 1);
        check("tmo_next_ch", bus.out_channel, 1);
        check("tmo_next_addr", bus.out_addr, t1);
        bus.out_ready = 1'b1;
        bus.done      = 1'b1;
        @(negedge clock_clk);
        bus.out_ready = 1'b0;
        bus.done      = 1'b0;
        check("hs_done_ignored", busy, 1);
        bus.done = 1'b1;
        @(negedge clock_clk);
        bus.done = 1'b0;
        check("done_after_hs", busy, 0);

        // Asynchronous reset while waiting with two commands still queued
        do_reset();
        r0 = ADDR_W'($urandom);
        r1 = ADDR_W'($urandom);
        r2 = ADDR_W'($urandom);
        r3 = ADDR_W'($urandom);
        set_addr(0, r0);
        set_addr(1, r1);
        pulse(2'b11);
        set_addr(0, r2);
        pulse(2'b01);
        ram_ready = 1'b1;
        serve(0, r0, 0, 0);
        @(negedge clock_clk);
        #1 reset_reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_addr", bus.out_addr, 0);
        check("arst_chan", bus.out_channel, 0);
        repeat (2) @(negedge clock_clk);
        reset_reset = 1'b0;
        expect_quiet("arst_queue_flushed", 15);
        set_addr(1, r3);
        pulse(2'b10);
        serve(1, r3, 0, 1);

        // Randomized run against the queue model
        do_reset();
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
